mult_dispatch: RTL

Front-end sequencer for the 16x16 shift-add multiplier (mult_32). It accepts operand pairs over a valid/ready handshake and launches the multiplier with an init pulse. It then waits for done, captures the 32-bit product and presents it downstream on a second valid/ready handshake. It also reports per-operation latency and flags a hung multiplier via a watchdog.

---
 rtl/mult_dispatch_if.sv | 24 ++
 rtl/mult_dispatch.sv | 93 +++++++++
 2 files changed

// File: rtl/mult_dispatch_if.sv
// Operand and product handshakes between mult_dispatch and its neighbours.
// The slave modport is the dispatcher's view; master is the producer/consumer side.
interface mult_dispatch_if #(
    parameter int W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_A;
    logic [W-1:0]     in_B;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_pp;
    logic [7:0]       out_cycles;

    modport slave (
        input  in_valid, in_A, in_B, out_ready,
        output in_ready, out_valid, out_pp, out_cycles
    );

    modport master (
        output in_valid, in_A, in_B, out_ready,
        input  in_ready, out_valid, out_pp, out_cycles
    );
endinterface

// File: rtl/mult_dispatch.sv
// Sequencer in front of the shift-add multiplier: accepts operands, pulses init,
// waits for done with a watchdog, and holds the product plus its latency for downstream.
module mult_dispatch #(
    parameter int W           = 16,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    mult_dispatch_if.slave    bus,
    output logic              mult_init,
    output logic [W-1:0]      mult_A,
    output logic [W-1:0]      mult_B,
    input  logic [2*W-1:0]    mult_pp,
    input  logic              mult_done,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t     state_reg;
    logic [3:0] init_cnt_reg;
    logic [7:0] lat_reg;
    logic [7:0] lat_next;
    logic [7:0] wd_reg;

    // Latency saturates rather than wrapping so long waits never look short.
    always_comb begin
        lat_next = lat_reg;
        if (lat_reg != 8'hFF)
            lat_next = lat_reg + 8'd1;
    end

    assign bus.in_ready = (state_reg == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            init_cnt_reg   <= '0;
            lat_reg        <= '0;
            wd_reg         <= '0;
            mult_init      <= 1'b0;
            mult_A         <= '0;
            mult_B         <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_pp     <= '0;
            bus.out_cycles <= '0;
            err_timeout    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        mult_A       <= bus.in_A;
                        mult_B       <= bus.in_B;
                        lat_reg      <= '0;
                        init_cnt_reg <= '0;
                        mult_init    <= 1'b1;
                        state_reg    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // mult_done is deliberately not looked at while init is asserted.
                    lat_reg      <= lat_next;
                    init_cnt_reg <= init_cnt_reg + 4'd1;
                    if (init_cnt_reg == 4'(INIT_CYCLES - 1)) begin
                        mult_init <= 1'b0;
                        wd_reg    <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    lat_reg <= lat_next;
                    wd_reg  <= wd_reg + 8'd1;
                    if (mult_done) begin
                        bus.out_pp     <= mult_pp;
                        bus.out_cycles <= lat_next;
                        bus.out_valid  <= 1'b1;
                        state_reg      <= HOLD;
                    end else if (wd_reg >= 8'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
